// File: rtl/vec_lsu_pkg.sv
// Shared types and sizing helpers for the strided vector load/store unit.
package vec_lsu_pkg;

    // Top-level sequencing states of the load/store unit.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    // Byte distance between consecutive elements for a unit-strided access.
    function automatic int unsigned unit_stride_bytes(input int unsigned sew);
        return sew / 32'd8;
    endfunction

    // Number of SEW-wide elements held by a register group.
    function automatic int unsigned calc_vlmax(input int unsigned vlen,
                                               input int unsigned lmul,
                                               input int unsigned sew);
        return (vlen * lmul) / sew;
    endfunction

endpackage

// File: rtl/vec_lsu_addr_gen.sv
// Running element address: loaded with the base and stride at command start,
// then advanced by the latched stride once per accepted request.
module vec_lsu_addr_gen #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] base,
    input  logic [XLEN-1:0] stride,
    output logic [XLEN-1:0] addr
);

    logic [XLEN-1:0] addr_r;
    logic [XLEN-1:0] stride_r;

    // Capture base/stride on load; add the stride on each step (wraps silently).
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            addr_r   <= {XLEN{1'b0}};
            stride_r <= {XLEN{1'b0}};
        end else if (load) begin
            addr_r   <= base;
            stride_r <= stride;
        end else if (step) begin
            addr_r   <= addr_r + stride_r;
        end else begin
            addr_r   <= addr_r;
        end
    end

    assign addr = addr_r;

endmodule

// File: rtl/vec_lsu_strided.sv
// Strided vector load/store unit: one element request at a time over a
// ready/valid memory port, assembling loads into vd_data.
module vec_lsu_strided
    import vec_lsu_pkg::*;
#(
    parameter  int unsigned XLEN     = 32,
    parameter  int unsigned VLEN     = 512,
    parameter  int unsigned SEW      = 32,
    parameter  int unsigned LMUL     = 1,
    parameter  int unsigned MAX_VLEN = 4096,
    localparam int unsigned VLMAX    = calc_vlmax(VLEN, LMUL, SEW),
    localparam int unsigned VL_W     = $clog2(VLMAX + 1)
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic                is_store,
    input  logic                stride_sel,
    input  logic [XLEN-1:0]     rs1_data,
    input  logic [XLEN-1:0]     rs2_data,
    input  logic [VL_W-1:0]     vl,
    input  logic [MAX_VLEN-1:0] vs3_data,
    output logic                mem_req,
    output logic                mem_we,
    output logic [XLEN-1:0]     mem_addr,
    output logic [SEW-1:0]      mem_wdata,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [SEW-1:0]      mem_rdata,
    output logic [MAX_VLEN-1:0] vd_data,
    output logic                busy,
    output logic                done
);

    localparam int unsigned BUF_W = VLMAX * SEW;

    lsu_state_e            state_r, state_nxt_s;
    logic [VL_W-1:0]       idx_r, idx_nxt_s;
    logic [VL_W-1:0]       eff_vl_r, eff_vl_s;
    logic                  is_store_r, store_nxt_s;
    logic [BUF_W-1:0]      vs3_r, src_s;
    logic [BUF_W-1:0]      buf_r, buf_nxt_s;
    logic [MAX_VLEN-1:0]   vd_data_r;
    logic [SEW-1:0]        wdata_nxt_s, mem_wdata_r;
    logic                  mem_req_r, mem_we_r, busy_r, done_r;
    logic                  start_s, req_hs_s, resp_hs_s, last_s;
    logic [XLEN-1:0]       stride_s, addr_s;

    assign start_s   = (state_r == IDLE) && start;
    assign req_hs_s  = (state_r == REQ) && mem_ready;
    assign resp_hs_s = (state_r == RESP) && mem_rvalid;
    assign last_s    = ((idx_r + VL_W'(1)) == eff_vl_r);
    assign eff_vl_s  = (vl > VL_W'(VLMAX)) ? VL_W'(VLMAX) : vl;
    assign stride_s  = stride_sel ? XLEN'(unit_stride_bytes(SEW)) : rs2_data;

    vec_lsu_addr_gen #(
        .XLEN (XLEN)
    ) u_addr_gen (
        .clk    (clk),
        .n_rst  (n_rst),
        .load   (start_s),
        .step   (req_hs_s),
        .base   (rs1_data),
        .stride (stride_s),
        .addr   (addr_s)
    );

    // Next-state and next element index for the request/response sequence.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    idx_nxt_s   = {VL_W{1'b0}};
                    state_nxt_s = (eff_vl_s == VL_W'(0)) ? DONE : REQ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                if (mem_ready) begin
                    if (is_store_r) begin
                        idx_nxt_s   = idx_r + VL_W'(1);
                        state_nxt_s = last_s ? DONE : REQ;
                    end else begin
                        state_nxt_s = RESP;
                    end
                end else begin
                    state_nxt_s = REQ;
                end
            end
            RESP: begin
                if (mem_rvalid) begin
                    idx_nxt_s   = idx_r + VL_W'(1);
                    state_nxt_s = last_s ? DONE : REQ;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
                idx_nxt_s   = {VL_W{1'b0}};
            end
        endcase
    end

    // Store element for the next request; the source is still on the input
    // bus during the start cycle and comes from the captured copy afterwards.
    always_comb begin
        src_s       = (state_r == IDLE) ? vs3_data[BUF_W-1:0] : vs3_r;
        store_nxt_s = (state_r == IDLE) ? is_store : is_store_r;
        wdata_nxt_s = {SEW{1'b0}};
        for (int i = 0; i < int'(VLMAX); i++) begin
            wdata_nxt_s = wdata_nxt_s |
                          (src_s[i*SEW +: SEW] & {SEW{idx_nxt_s == VL_W'(i)}});
        end
    end

    // Load buffer with the incoming response merged into element idx.
    always_comb begin
        buf_nxt_s = buf_r;
        if (resp_hs_s) begin
            buf_nxt_s[int'(idx_r)*SEW +: SEW] = mem_rdata;
        end else begin
            buf_nxt_s = buf_r;
        end
    end

    // State and element counter registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r <= IDLE;
            idx_r   <= {VL_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
        end
    end

    // Command capture at start and load-buffer update on each response.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            eff_vl_r   <= {VL_W{1'b0}};
            is_store_r <= 1'b0;
            vs3_r      <= {BUF_W{1'b0}};
            buf_r      <= {BUF_W{1'b0}};
        end else if (start_s) begin
            eff_vl_r   <= eff_vl_s;
            is_store_r <= is_store;
            vs3_r      <= vs3_data[BUF_W-1:0];
            buf_r      <= {BUF_W{1'b0}};
        end else begin
            buf_r      <= buf_nxt_s;
        end
    end

    // Registered memory-request and status outputs, derived from the next state.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_wdata_r <= {SEW{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            mem_req_r   <= (state_nxt_s == REQ);
            mem_we_r    <= (state_nxt_s == REQ) && store_nxt_s;
            mem_wdata_r <= ((state_nxt_s == REQ) && store_nxt_s) ? wdata_nxt_s
                                                                 : {SEW{1'b0}};
            busy_r      <= (state_nxt_s == REQ) || (state_nxt_s == RESP);
            done_r      <= (state_nxt_s == DONE);
        end
    end

    // Publish the assembled vector as the final load response completes, so it
    // is visible during the DONE cycle; stores and empty loads leave it alone.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            vd_data_r <= {MAX_VLEN{1'b0}};
        end else if ((state_r == RESP) && (state_nxt_s == DONE)) begin
            vd_data_r <= MAX_VLEN'(buf_nxt_s);
        end else begin
            vd_data_r <= vd_data_r;
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = addr_s;
    assign mem_wdata = mem_wdata_r;
    assign vd_data   = vd_data_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_vec_lsu_strided.sv
// Directed self-checking bench for vec_lsu_strided.
module tb_vec_lsu_strided;

    localparam int XLEN     = 32;
    localparam int SEW      = 32;
    localparam int VL_W     = 5;
    localparam int MAX_VLEN = 4096;

    logic                clk;
    logic                n_rst;
    logic                start;
    logic                is_store;
    logic                stride_sel;
    logic [XLEN-1:0]     rs1_data;
    logic [XLEN-1:0]     rs2_data;
    logic [VL_W-1:0]     vl;
    logic [MAX_VLEN-1:0] vs3_data;
    logic                mem_req;
    logic                mem_we;
    logic [XLEN-1:0]     mem_addr;
    logic [SEW-1:0]      mem_wdata;
    logic                mem_ready;
    logic                mem_rvalid;
    logic [SEW-1:0]      mem_rdata;
    logic [MAX_VLEN-1:0] vd_data;
    logic                busy;
    logic                done;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int done_cnt = 0;
    int req_cnt  = 0;

    vec_lsu_strided dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .is_store   (is_store),
        .stride_sel (stride_sel),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .vl         (vl),
        .vs3_data   (vs3_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .vd_data    (vd_data),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event counters sampled on the active edge.
    always @(posedge clk) begin
        if (mem_req && mem_ready && mem_we) wr_cnt <= wr_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (mem_req) req_cnt <= req_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Load with ready=1 and a response one cycle after each acceptance;
    // memory returns the element address as data.
    task automatic run_load(input logic [31:0] base, input logic [31:0] rs2,
                            input logic sel, input int vlv, input int n);
        logic [31:0] stride;
        logic [31:0] a;
        logic [31:0] e;
        stride = sel ? 32'd4 : rs2;
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; stride_sel = sel;
        rs1_data = base; rs2_data = rs2; vl = vlv[4:0];
        mem_ready = 1'b1; mem_rvalid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            a = base + 32'(k) * stride;
            chk($sformatf("ld_req[%0d]", k), 64'(mem_req), 64'd1);
            chk($sformatf("ld_we[%0d]", k), 64'(mem_we), 64'd0);
            chk($sformatf("ld_addr[%0d]", k), 64'(mem_addr), 64'(a));
            chk($sformatf("ld_busy[%0d]", k), 64'(busy), 64'd1);
            @(negedge clk);
            chk($sformatf("ld_req_resp[%0d]", k), 64'(mem_req), 64'd0);
            mem_rvalid = 1'b1; mem_rdata = a;
            @(negedge clk);
            mem_rvalid = 1'b0;
        end
        chk("ld_done", 64'(done), 64'd1);
        chk("ld_busy_done", 64'(busy), 64'd0);
        for (int i = 0; i < 16; i++) begin
            e = (i < n) ? base + 32'(i) * stride : 32'd0;
            chk($sformatf("ld_vd[%0d]", i), 64'(vd_data[i*32 +: 32]), 64'(e));
        end
        chk("ld_vd_upper", 64'(|vd_data[MAX_VLEN-1:512]), 64'd0);
        @(negedge clk);
        chk("ld_done_off", 64'(done), 64'd0);
    endtask

    logic [MAX_VLEN-1:0] vd_prev;
    int wr0, dc0, rq0;

    initial begin
        n_rst = 1'b0; start = 1'b0; is_store = 1'b0; stride_sel = 1'b0;
        rs1_data = 32'd0; rs2_data = 32'd0; vl = 5'd0; vs3_data = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", 64'(mem_req), 64'd0);
        chk("rst_we", 64'(mem_we), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_vd", 64'(|vd_data), 64'd0);
        n_rst = 1'b1;

        // Unit-stride load of 16 elements from 0x100.
        run_load(32'h100, 32'h0, 1'b1, 16, 16);
        // Constant stride 0x20 from 0x200, 4 elements.
        run_load(32'h200, 32'h20, 1'b0, 4, 4);

        // Store of 3 elements with a two-cycle stall on element 1.
        vd_prev = vd_data;
        wr0 = wr_cnt; dc0 = done_cnt;
        vs3_data = '0;
        vs3_data[31:0] = 32'hA; vs3_data[63:32] = 32'hB;
        vs3_data[95:64] = 32'hC; vs3_data[127:96] = 32'hDEAD;
        @(negedge clk);
        start = 1'b1; is_store = 1'b1; stride_sel = 1'b1;
        rs1_data = 32'h400; vl = 5'd3; mem_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; vs3_data[63:32] = 32'h77;
        chk("st_req0", 64'(mem_req), 64'd1);
        chk("st_we0", 64'(mem_we), 64'd1);
        chk("st_addr0", 64'(mem_addr), 64'h400);
        chk("st_wdata0", 64'(mem_wdata), 64'hA);
        @(negedge clk);
        chk("st_addr1", 64'(mem_addr), 64'h404);
        chk("st_wdata1", 64'(mem_wdata), 64'hB);
        mem_ready = 1'b0;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            chk($sformatf("st_stall_req[%0d]", s), 64'(mem_req), 64'd1);
            chk($sformatf("st_stall_addr[%0d]", s), 64'(mem_addr), 64'h404);
            chk($sformatf("st_stall_wdata[%0d]", s), 64'(mem_wdata), 64'hB);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        chk("st_addr2", 64'(mem_addr), 64'h408);
        chk("st_wdata2", 64'(mem_wdata), 64'hC);
        @(negedge clk);
        chk("st_done", 64'(done), 64'd1);
        chk("st_req_done", 64'(mem_req), 64'd0);
        @(negedge clk);
        chk("st_writes", 64'(wr_cnt - wr0), 64'd3);
        chk("st_done_pulses", 64'(done_cnt - dc0), 64'd1);
        chk("st_vd_same", 64'(|(vd_data ^ vd_prev)), 64'd0);

        // Negative stride with address wrap.
        run_load(32'h8, 32'hFFFF_FFFC, 1'b0, 4, 4);

        // vl = 0: immediate done, no traffic, vd_data untouched.
        vd_prev = vd_data; rq0 = req_cnt;
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; stride_sel = 1'b1; rs1_data = 32'h500; vl = 5'd0;
        @(negedge clk);
        start = 1'b0;
        chk("vl0_done", 64'(done), 64'd1);
        chk("vl0_busy", 64'(busy), 64'd0);
        chk("vl0_req", 64'(mem_req), 64'd0);
        @(negedge clk);
        @(negedge clk);
        chk("vl0_done_off", 64'(done), 64'd0);
        chk("vl0_no_req", 64'(req_cnt - rq0), 64'd0);
        chk("vl0_vd_same", 64'(|(vd_data ^ vd_prev)), 64'd0);

        // vl = 20 clamps to 16 elements.
        run_load(32'h300, 32'h0, 1'b1, 20, 16);

        // Reset while waiting for the response of element 5.
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; stride_sel = 1'b1; rs1_data = 32'h100; vl = 5'd16;
        mem_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            mem_rvalid = 1'b1; mem_rdata = 32'(k);
            @(negedge clk);
            mem_rvalid = 1'b0;
        end
        @(negedge clk);
        chk("rr_in_resp", 64'(busy & ~mem_req), 64'd1);
        #1 n_rst = 1'b0;
        #1;
        chk("rr_req", 64'(mem_req), 64'd0);
        chk("rr_we", 64'(mem_we), 64'd0);
        chk("rr_addr", 64'(mem_addr), 64'd0);
        chk("rr_wdata", 64'(mem_wdata), 64'd0);
        chk("rr_busy", 64'(busy), 64'd0);
        chk("rr_done", 64'(done), 64'd0);
        chk("rr_vd", 64'(|vd_data), 64'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD;
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("rr_post_busy", 64'(busy), 64'd0);
        chk("rr_post_req", 64'(mem_req), 64'd0);
        chk("rr_post_done", 64'(done), 64'd0);
        chk("rr_post_vd", 64'(|vd_data), 64'd0);

        // Fresh command after reset.
        run_load(32'h40, 32'h0, 1'b1, 2, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vec_lsu_strided.md
Name: vec_lsu_strided

Overview:
Vector load/store unit for the co-processor.
- Executes unit-strided and constant-strided vector loads and stores of 1..VLMAX elements, each SEW bits wide.
- Issues one element request at a time over a ready/valid memory interface.
- For loads, assembles the vector into vd_data for the register file.
- For stores, streams elements of a captured source register to memory.
- Sits between the vector controller/decoder, the scalar operand path and main memory.

Parameters:
XLEN, 32, scalar/address width
VLEN, 512, bits per vector register
SEW, 32, element width in bits (8, 16 or 32)
LMUL, 1, register grouping
MAX_VLEN, 4096, width of vector data buses
VLMAX, VLEN*LMUL/SEW (derived localparam), maximum element count
VL_W, $clog2(VLMAX+1) (derived localparam), width of vl

Ports:
clk  in  1  clock
n_rst  in  1  asynchronous active-low reset
start  in  1  one-cycle command strobe; sampled only in IDLE
is_store  in  1  1 = store, 0 = load
stride_sel  in  1  1 = unit stride (SEW/8 bytes), 0 = stride rs2_data
rs1_data  in  XLEN  base address
rs2_data  in  XLEN  byte stride (two's complement)
vl  in  VL_W  requested element count
vs3_data  in  MAX_VLEN  store source; element i = bits [i*SEW +: SEW]
mem_req  out  1  request valid
mem_we  out  1  1 = write
mem_addr  out  XLEN  element byte address
mem_wdata  out  SEW  store data
mem_ready  in  1  memory accepts request when mem_req && mem_ready
mem_rvalid  in  1  load response valid
mem_rdata  in  SEW  load response data
vd_data  out  MAX_VLEN  assembled load vector
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock, clk. Reset n_rst is asynchronous and active-low.
- Reset values: every output and all internal registers are 0; the FSM is in IDLE.
- Reset mid-operation: abort immediately with no further memory requests. vd_data and the element buffer clear. A response arriving during or after reset is ignored.
- FSM (lsu_state_e): IDLE, REQ, RESP, DONE.
- IDLE, start=1:
  - latch rs1, stride (SEW/8 if stride_sel, else rs2), is_store, vs3_data, and eff_vl = min(vl, VLMAX);
  - clear the element buffer and element counter idx;
  - go to REQ, or to DONE if eff_vl == 0.
- start outside IDLE is ignored.
- REQ:
  - mem_req=1, mem_addr = base + idx*stride modulo 2^XLEN (the first element is exactly rs1), mem_we = is_store;
  - mem_wdata = vs3 element idx for stores, 0 for loads;
  - hold all request outputs stable until mem_ready.
- On handshake:
  - store: idx++. If idx reaches eff_vl, go to DONE; otherwise stay in REQ (back-to-back, one element per cycle when ready stays high).
  - load: go to RESP.
- RESP: mem_req=0; wait for mem_rvalid. On mem_rvalid, write mem_rdata into element idx, then idx++. Go to DONE if idx reaches eff_vl, else go to REQ. mem_rvalid outside RESP is ignored.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- busy = (state != IDLE && state != DONE).
- vd_data on a load:
  - updates from the buffer in the DONE cycle; elements >= eff_vl and bits >= VLMAX*SEW are 0;
  - holds its value until the next load's DONE or a reset.
- vd_data is unchanged by stores and by loads with vl=0.
- The address advances by adding the latched stride to a running address register, not by multiplying. Wrap at 2^XLEN is silent.
- Latency with ready=1 and rvalid the cycle after acceptance:
  - load: start at T, first req at T+1, done at T+2*eff_vl+1;
  - store: done at T+eff_vl+1;
  - vl=0: done at T+1 with no memory traffic.

Decomposition:
- vec_lsu_pkg: lsu_state_e typedef; helper functions for unit stride (SEW/8) and the VLMAX calculation.
- Sub-module vec_lsu_addr_gen holds the base/stride/running-address register:
  - inputs: load, step;
  - output: current address.
- The FSM, element counter, store-data mux and load buffer stay in vec_lsu_strided.

Test Plan:
- Unit-stride load, rs1=0x100, vl=16, ready=1, rdata=addr: addresses 0x100,0x104..0x13C; vd_data element i = 0x100+4i; done at T+33.
- Strided load, rs2=0x20, rs1=0x200, vl=4: addresses 0x200,0x220,0x240,0x260; elements 4..15 of vd_data = 0.
- Store, vl=3, vs3 elements 0xA,0xB,0xC, mem_ready low for 2 cycles on element 1: mem_addr and mem_wdata are held during the stall; exactly 3 writes occur; done occurs once.
- Strided load with rs2=0xFFFFFFFC (−4), rs1=0x8, vl=4: addresses 0x8,0x4,0x0,0xFFFFFFFC.
- vl=0: done pulses at T+1, mem_req is never asserted, vd_data is unchanged. vl=20: clamped to 16 accesses.
- n_rst pulled low during RESP of element 5: all outputs go to 0 at once; a later rvalid is ignored; a fresh start works normally.
